// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 bus bundle used between the interconnect slave port and the SRAM target.
// The slave modport is the target view; the master modport is the initiator view.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   ADR;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic [DW/8-1:0] SEL;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic            ACK;
  logic            ERR;

  modport slave (
    input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    output DAT_R, ACK, ERR
  );

  modport master (
    output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    input  DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone B4 single-port SRAM target with classic cycles and zero-wait incrementing bursts.
// Handshake: a beat completes on any rising edge where CYC & STB & ACK are all high.
module wb_sram_slave #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic       clk,
  input  logic       rstn,
  wb_if.slave        s,
  output logic [1:0] o_dbg_state
);

  localparam int NB    = WB_DATA_WIDTH / 8;
  localparam int LB    = (NB > 1) ? $clog2(NB) : 0;
  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLASSIC = 2'd1,
    ST_BURST   = 2'd2
  } state_t;

  logic [WB_DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                   r_state;
  logic                     r_ack;
  logic [WB_DATA_WIDTH-1:0] r_dat_r;

  state_t                   w_state_nxt;
  logic                     w_ack_nxt;
  logic                     w_rd_en;
  logic [MEM_ADDR_BITS-1:0] w_rd_idx;
  logic [MEM_ADDR_BITS-1:0] w_widx;
  logic [MEM_ADDR_BITS-1:0] w_inc;
  logic [MEM_ADDR_BITS-1:0] w_mask;
  logic [MEM_ADDR_BITS-1:0] w_nxt;
  logic                     w_req;
  logic                     w_beat;
  logic                     w_unused_adr;

  // Upper address bits are ignored so the RAM mirrors across its window.
  assign w_widx       = s.ADR[LB +: MEM_ADDR_BITS];
  assign w_unused_adr = ^s.ADR;
  assign w_req        = s.CYC & s.STB;
  assign w_beat       = w_req & r_ack;

  always_comb begin
    w_mask = '0;
    case (s.BTE)
      2'b01:   w_mask = MEM_ADDR_BITS'(3);
      2'b10:   w_mask = MEM_ADDR_BITS'(7);
      2'b11:   w_mask = MEM_ADDR_BITS'(15);
      default: w_mask = '0;
    endcase
    w_inc = w_widx + 1'b1;
    if (s.BTE == 2'b00) w_nxt = w_inc;
    else                w_nxt = (w_widx & ~w_mask) | (w_inc & w_mask);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_idx    = w_widx;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_ack_nxt   = 1'b1;
          w_rd_en     = ~s.WE;
          w_state_nxt = (s.CTI == CTI_INCR) ? ST_BURST : ST_CLASSIC;
        end
      end
      ST_CLASSIC: begin
        w_state_nxt = ST_IDLE;
      end
      ST_BURST: begin
        if (!s.CYC) begin
          w_state_nxt = ST_IDLE;
        end else if (w_beat) begin
          // Any CTI other than incrementing (end, classic, reserved) closes the burst.
          if (s.CTI == CTI_INCR) begin
            w_ack_nxt = 1'b1;
            w_rd_en   = 1'b1;
            w_rd_idx  = w_nxt;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (s.STB) begin
          w_ack_nxt = 1'b1;
          w_rd_en   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_dat_r <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      if (w_rd_en) r_dat_r <= r_mem[w_rd_idx];
    end
  end

  // r_ack is cleared by reset, so no write can commit while or right after reset.
  always_ff @(posedge clk) begin
    if (w_beat && s.WE) begin
      for (int b = 0; b < NB; b++) begin
        if (s.SEL[b]) r_mem[w_widx][8*b +: 8] <= s.DAT_W[8*b +: 8];
      end
    end
  end

  assign s.ACK       = r_ack;
  assign s.DAT_R     = r_dat_r;
  assign s.ERR       = 1'b0;
  assign o_dbg_state = r_state;

endmodule
